// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment scanner: sign, hundreds, tens and ones, with frame-aligned digit updates.
// Define SEVEN_SEG_BLANK_EN to blank leading zeros on the hundreds and tens digits.
module seven_seg_scan #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       negative,
  input  logic       load,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame
);

  localparam int TICK_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_ERR   = 7'b0000110;

  logic [TICK_W-1:0] tick;
  logic [1:0]        idx;

  logic [3:0] h_p0, t_p0, o_p0;
  logic       neg_p0;
  logic       vld_p0;

  logic [3:0] h_p1, t_p1, o_p1;
  logic       neg_p1;

  logic       tick_end;
  logic       wrap;
  logic       blank_h;
  logic       blank_t;
  logic [3:0] an_nxt;
  logic [6:0] seg_nxt;

  function automatic logic [6:0] enc_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_ERR;
    endcase
    return s;
  endfunction

  assign tick_end = (tick == TICK_LAST);
  assign wrap     = tick_end && (idx == 2'd3);

`ifdef SEVEN_SEG_BLANK_EN
  assign blank_h = (h_p1 == 4'd0);
  assign blank_t = blank_h && (t_p1 == 4'd0);
`else
  assign blank_h = 1'b0;
  assign blank_t = 1'b0;
`endif

  always_comb begin
    an_nxt  = 4'b1111;
    seg_nxt = SEG_BLANK;
    an_nxt[idx] = 1'b0;
    case (idx)
      2'd0: seg_nxt = enc_digit(o_p1);
      2'd1: seg_nxt = blank_t ? SEG_BLANK : enc_digit(t_p1);
      2'd2: seg_nxt = blank_h ? SEG_BLANK : enc_digit(h_p1);
      default: seg_nxt = neg_p1 ? SEG_MINUS : SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick   <= '0;
      idx    <= 2'd0;
      h_p0   <= 4'd0;
      t_p0   <= 4'd0;
      o_p0   <= 4'd0;
      neg_p0 <= 1'b0;
      vld_p0 <= 1'b0;
      h_p1   <= 4'd0;
      t_p1   <= 4'd0;
      o_p1   <= 4'd0;
      neg_p1 <= 1'b0;
      an     <= 4'b1111;
      seg    <= SEG_BLANK;
      frame  <= 1'b0;
    end else begin
      tick <= tick_end ? '0 : tick + 1'b1;
      if (tick_end)
        idx <= idx + 2'd1;

      // p0: pending capture; p1: display registers, swapped only at the frame wrap
      if (wrap) begin
        if (load) begin
          h_p1   <= hundreds;
          t_p1   <= tens;
          o_p1   <= ones;
          neg_p1 <= negative;
        end else if (vld_p0) begin
          h_p1   <= h_p0;
          t_p1   <= t_p0;
          o_p1   <= o_p0;
          neg_p1 <= neg_p0;
        end
        vld_p0 <= 1'b0;
      end else if (load) begin
        h_p0   <= hundreds;
        t_p0   <= tens;
        o_p0   <= ones;
        neg_p0 <= negative;
        vld_p0 <= 1'b1;
      end

      // output stage: drive the digit selected before this edge
      an    <= an_nxt;
      seg   <= seg_nxt;
      frame <= wrap;
    end
  end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 The block SHALL have parameter REFRESH_DIV, default 100000: clk cycles each digit is held, legal range 2..2^20.
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 hundreds  input  4  BCD hundreds digit from the converter stage.
REQ-006 tens  input  4  BCD tens digit.
REQ-007 ones  input  4  BCD ones digit.
REQ-008 negative  input  1  sign of the converted value; 1 means show a minus.
REQ-009 load  input  1  single-cycle strobe that captures hundreds, tens, ones and negative.
REQ-010 an  output  4  active-low anode enables: an[3] is the sign, an[2] hundreds, an[1] tens, an[0] ones.
REQ-011 seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-012 frame  output  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.

Function
REQ-013 A tick counter SHALL count 0..REFRESH_DIV-1 and wrap to 0.
- At terminal count, digit index idx (2 bits) SHALL increment, wrapping 3 -> 0.
REQ-014 On load=1, the inputs SHALL be captured into pending registers and pending_valid SHALL be set.
REQ-015 On the edge where idx wraps 3 -> 0 with pending_valid=1, pending SHALL copy to the display registers and pending_valid SHALL clear.
- This prevents a frame from mixing old and new digits.
REQ-016 If load and the 3 -> 0 wrap occur in the same cycle, the load data SHALL go directly to the display registers and pending_valid SHALL end at 0.
REQ-017 A load while pending_valid=1 SHALL overwrite pending (last load wins).
REQ-018 an and seg SHALL be registered, reflecting the idx and display registers sampled at the previous edge (1-cycle latency).
- Exactly one bit of an SHALL be 0: bit idx.
REQ-019 Digit encodings (seg) SHALL be:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
REQ-020 Non-BCD codes 10..15 SHALL display E=0000110.
REQ-021 Digit 3 SHALL show minus=0111111 when the registered negative=1, else blank=1111111.
REQ-022 frame SHALL assert for exactly the cycle after the 3 -> 0 wrap edge.
REQ-023 Inputs SHALL only be sampled on load; changes without load SHALL have no effect.

Reset
REQ-024 While reset=1:
- an=1111, seg=1111111, frame=0
- tick counter and idx = 0
- pending, display and negative registers = 0; pending_valid = 0
REQ-025 Reset SHALL take effect immediately, regardless of the clock or any load in progress.
REQ-026 The first rising edge after reset release SHALL drive an=1110 with ones digit 0 (seg=1000000).

Configuration
REQ-027 The macro SEVEN_SEG_BLANK_EN SHALL compile leading-zero blanking in or out.
- Defined: hundreds SHALL be blank (1111111) when 0; tens SHALL be blank when hundreds=0 and tens=0; ones SHALL never be blanked.
- Undefined: all three digits SHALL always show their encoding, including leading zeros.

Verification (REFRESH_DIV=4)
REQ-028 Reset, then release -> an=1110 and seg=1000000 at the first edge; an sequence 1110, 1101, 1011, 0111, each held 4 cycles; frame pulses every 16 cycles.
REQ-029 load h=1, t=2, o=8, neg=1 mid-frame -> no change until the wrap; then an=0111 with seg=0111111, an=1011 with seg=1111001, an=1101 with seg=0100100, an=1110 with seg=0000000.
REQ-030 load h=0, t=0, o=7, neg=0 -> with SEVEN_SEG_BLANK_EN: digits 2 and 1 show 1111111 and ones shows 1111000; without it: digits 2 and 1 show 1000000.
REQ-031 load on the exact wrap cycle, then a second load one cycle later -> the first data displays in the current frame and the second appears at the next wrap.
REQ-032 load tens=4'hC -> the tens digit shows 0000110.
REQ-033 Assert reset mid-frame between clock edges -> an=1111 and seg=1111111 immediately; the display registers read 0 after release.
